fp_mult: RTL and testbench

- Pipelined IEEE-754 single-precision floating-point multiplier.
- Used by the floating-point arithmetic layer; a wrapper gates `clk_en` for a fixed window, then samples `result`.
- Fixed latency counted in enabled clock cycles; the pipeline stalls whenever `clk_en` is low.

---
 rtl/fp_mult.sv | 134 +++++++++++++
 tb/tb_fp_mult.sv | 119 +++++++++++
 2 files changed

// File: rtl/fp_mult.sv
// Pipelined IEEE-754 binary32 multiplier with flush-to-zero and round-to-nearest-even.
// Stage 1 captures operands, stage 2 decodes and multiplies, and stage 3 rounds and packs into a delay tail.
module fp_mult #(
  parameter int LATENCY = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  localparam logic [1:0] CLS_NORMAL = 2'd0;
  localparam logic [1:0] CLS_NAN    = 2'd1;
  localparam logic [1:0] CLS_INF    = 2'd2;
  localparam logic [1:0] CLS_ZERO   = 2'd3;
  localparam int TAIL = LATENCY - 2;

  logic [31:0]       a_r, b_r;
  logic              sign2_r;
  logic [1:0]        cls2_r;
  logic signed [9:0] exp2_r;
  logic [47:0]       prod2_r;
  logic [31:0]       tail_r [TAIL];

  logic              a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [1:0]        cls_s;
  logic [47:0]       prod_s;
  logic signed [9:0] exp_sum_s;

  assign a_zero_s  = (a_r[30:23] == 8'd0);
  assign b_zero_s  = (b_r[30:23] == 8'd0);
  assign a_inf_s   = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
  assign b_inf_s   = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
  assign a_nan_s   = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
  assign b_nan_s   = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
  assign prod_s    = {24'd0, 1'b1, a_r[22:0]} * {24'd0, 1'b1, b_r[22:0]};
  assign exp_sum_s = $signed({2'b00, a_r[30:23]}) + $signed({2'b00, b_r[30:23]}) - 10'sd127;

  // Operand classification in special-case priority order
  always_comb begin
    cls_s = CLS_NORMAL;
    if (a_nan_s || b_nan_s) begin
      cls_s = CLS_NAN;
    end else if ((a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      cls_s = CLS_NAN;
    end else if (a_inf_s || b_inf_s) begin
      cls_s = CLS_INF;
    end else if (a_zero_s || b_zero_s) begin
      cls_s = CLS_ZERO;
    end else begin
      cls_s = CLS_NORMAL;
    end
  end

  logic signed [9:0] exp_norm_s, exp_fin_s;
  logic [22:0]       mant_s;
  logic              guard_s, round_s, sticky_s, round_up_s;
  logic [23:0]       mant_rnd_s;
  logic [31:0]       packed_s;

  // Normalize the [1,4) product and pick guard/round/sticky
  always_comb begin
    mant_s   = 23'd0;
    guard_s  = 1'b0;
    round_s  = 1'b0;
    sticky_s = 1'b0;
    exp_norm_s = exp2_r;
    if (prod2_r[47]) begin
      mant_s     = prod2_r[46:24];
      guard_s    = prod2_r[23];
      round_s    = prod2_r[22];
      sticky_s   = |prod2_r[21:0];
      exp_norm_s = exp2_r + 10'sd1;
    end else begin
      mant_s     = prod2_r[45:23];
      guard_s    = prod2_r[22];
      round_s    = prod2_r[21];
      sticky_s   = |prod2_r[20:0];
      exp_norm_s = exp2_r;
    end
  end

  assign round_up_s = guard_s & (round_s | sticky_s | mant_s[0]);
  assign mant_rnd_s = {1'b0, mant_s} + {23'd0, round_up_s};
  // A carry out of the mantissa leaves the fraction all zeros; only the exponent moves
  assign exp_fin_s  = mant_rnd_s[23] ? (exp_norm_s + 10'sd1) : exp_norm_s;

  // Final packing of specials and range limits
  always_comb begin
    packed_s = 32'h0000_0000;
    case (cls2_r)
      CLS_NAN:  packed_s = 32'h7FC0_0000;
      CLS_INF:  packed_s = {sign2_r, 8'hFF, 23'd0};
      CLS_ZERO: packed_s = {sign2_r, 31'd0};
      CLS_NORMAL: begin
        if (exp_fin_s >= 10'sd255) begin
          packed_s = {sign2_r, 8'hFF, 23'd0};
        end else if (exp_fin_s <= 10'sd0) begin
          packed_s = {sign2_r, 31'd0};
        end else begin
          packed_s = {sign2_r, exp_fin_s[7:0], mant_rnd_s[22:0]};
        end
      end
      default:  packed_s = 32'h0000_0000;
    endcase
  end

  // Pipeline registers: reset clears everything, clk_en low holds every stage
  always_ff @(posedge clock) begin
    if (reset) begin
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      sign2_r <= 1'b0;
      cls2_r  <= CLS_ZERO;
      exp2_r  <= 10'sd0;
      prod2_r <= 48'd0;
      for (int i = 0; i < TAIL; i++) tail_r[i] <= 32'd0;
    end else if (clk_en) begin
      a_r     <= dataa;
      b_r     <= datab;
      sign2_r <= a_r[31] ^ b_r[31];
      cls2_r  <= cls_s;
      exp2_r  <= exp_sum_s;
      prod2_r <= prod_s;
      tail_r[0] <= packed_s;
      for (int i = 1; i < TAIL; i++) tail_r[i] <= tail_r[i-1];
    end
  end

  assign result = tail_r[TAIL-1];

endmodule

// File: tb/tb_fp_mult.sv
// Directed self-checking bench for fp_mult: latency, arithmetic, specials, stall and reset.
module tb_fp_mult;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  fp_mult #(.LATENCY(5)) dut (
    .clock  (clock),
    .reset  (reset),
    .clk_en (clk_en),
    .dataa  (dataa),
    .datab  (datab),
    .result (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [31:0] a, input logic [31:0] b);
    clk_en = en;
    dataa  = a;
    datab  = b;
    @(posedge clock);
    #1;
  endtask

  logic [31:0] va [10];
  logic [31:0] vb [10];
  logic [31:0] vexp [10];

  initial begin
    va[0] = 32'h4000_0000; vb[0] = 32'h4040_0000; vexp[0] = 32'h40C0_0000;
    va[1] = 32'h3FC0_0000; vb[1] = 32'hC000_0000; vexp[1] = 32'hC040_0000;
    va[2] = 32'h3F80_0001; vb[2] = 32'h3F80_0001; vexp[2] = 32'h3F80_0002;
    va[3] = 32'h7F80_0000; vb[3] = 32'h0000_0000; vexp[3] = 32'h7FC0_0000;
    va[4] = 32'hFF80_0000; vb[4] = 32'h4000_0000; vexp[4] = 32'hFF80_0000;
    va[5] = 32'h7FC0_0001; vb[5] = 32'h3F80_0000; vexp[5] = 32'h7FC0_0000;
    va[6] = 32'h8000_0000; vb[6] = 32'h3F80_0000; vexp[6] = 32'h8000_0000;
    va[7] = 32'h7F00_0000; vb[7] = 32'h4000_0000; vexp[7] = 32'h7F80_0000;
    va[8] = 32'h0080_0000; vb[8] = 32'h3F00_0000; vexp[8] = 32'h0000_0000;
    va[9] = 32'h0000_0001; vb[9] = 32'h7F7F_FFFF; vexp[9] = 32'h0000_0000;

    // Reset state
    reset = 1'b1;
    step(1'b0, 32'd0, 32'd0);
    step(1'b1, 32'd0, 32'd0);
    check("reset_state", result, 32'h0000_0000);
    reset = 1'b0;

    // 2.0 x 3.0: exactly five enabled edges of latency
    step(1'b1, 32'h4000_0000, 32'h4040_0000);
    for (int k = 2; k <= 4; k++) step(1'b1, 32'd0, 32'd0);
    check("latency_not_early", result, 32'h0000_0000);
    step(1'b1, 32'd0, 32'd0);
    check("mul_2x3", result, 32'h40C0_0000);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h3F80_0000, 32'h3F80_0000);
      check("hold_after_en_drop", result, 32'h40C0_0000);
    end

    // Back-to-back stream through the full pipeline
    for (int k = 0; k < 14; k++) begin
      if (k < 10) step(1'b1, va[k], vb[k]);
      else        step(1'b1, 32'd0, 32'd0);
      if (k >= 4) check($sformatf("stream_%0d", k - 4), result, vexp[k - 4]);
    end

    // Stall: two enabled edges, three held cycles, then resume
    reset = 1'b1;
    step(1'b1, 32'd0, 32'd0);
    reset = 1'b0;
    step(1'b1, 32'h4000_0000, 32'h4040_0000);
    step(1'b1, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h3FC0_0000, 32'hC000_0000);
      check("stall_hold", result, 32'h0000_0000);
    end
    step(1'b1, 32'd0, 32'd0);
    check("stall_edge3", result, 32'h0000_0000);
    step(1'b1, 32'd0, 32'd0);
    check("stall_edge4", result, 32'h0000_0000);
    step(1'b1, 32'd0, 32'd0);
    check("stall_edge5", result, 32'h40C0_0000);
    step(1'b1, 32'd0, 32'd0);
    check("stall_inputs_ignored_a", result, 32'h0000_0000);
    step(1'b1, 32'd0, 32'd0);
    check("stall_inputs_ignored_b", result, 32'h0000_0000);

    // Reset with two products in flight
    step(1'b1, 32'h4000_0000, 32'h4040_0000);
    step(1'b1, 32'h3FC0_0000, 32'hC000_0000);
    reset = 1'b1;
    step(1'b1, 32'h7F80_0000, 32'h4000_0000);
    check("reset_mid_op", result, 32'h0000_0000);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 32'd0, 32'd0);
      check($sformatf("post_reset_%0d", k), result, 32'h0000_0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
